// File: rtl/hpdcache_req_scratchpad_responder_if.sv
// Request/response bundle between a requester (master) and the
// scratchpad responder (slave).
// Ports:
//   req_valid_i/req_ready_o  request handshake
//   req_addr_i/op/wdata/be   request payload
//   req_sid_i/req_tid_i      request IDs
//   req_need_rsp_i           response wanted
//   rsp_valid_o              response strobe (no backpressure)
//   rsp_rdata_o/sid/tid/err  response payload
interface hpdcache_req_scratchpad_responder_if #(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned AddrWidth = 49,
    parameter int unsigned SidWidth  = 3,
    parameter int unsigned TidWidth  = 6
);
    logic                     req_valid_i;
    logic                     req_ready_o;
    logic [AddrWidth-1:0]     req_addr_i;
    logic [1:0]               req_op_i;
    logic [DataWidth-1:0]     req_wdata_i;
    logic [DataWidth/8-1:0]   req_be_i;
    logic [SidWidth-1:0]      req_sid_i;
    logic [TidWidth-1:0]      req_tid_i;
    logic                     req_need_rsp_i;
    logic                     rsp_valid_o;
    logic [DataWidth-1:0]     rsp_rdata_o;
    logic [SidWidth-1:0]      rsp_sid_o;
    logic [TidWidth-1:0]      rsp_tid_o;
    logic                     rsp_error_o;

    modport master (
        output req_valid_i, req_addr_i, req_op_i, req_wdata_i,
        output req_be_i, req_sid_i, req_tid_i, req_need_rsp_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o,
        input  rsp_sid_o, rsp_tid_o, rsp_error_o
    );

    modport slave (
        input  req_valid_i, req_addr_i, req_op_i, req_wdata_i,
        input  req_be_i, req_sid_i, req_tid_i, req_need_rsp_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o,
        output rsp_sid_o, rsp_tid_o, rsp_error_o
    );
endinterface

// File: rtl/hpdcache_req_scratchpad_responder.sv
// HPDcache request-port responder backed by a byte-enabled scratchpad.
// Ports: clk_i, rst_ni (async, active-low), bus (slave modport).
// After reset the scratchpad is zeroed for Depth cycles (ready low),
// then requests are served one per cycle with a fixed response latency.
module hpdcache_req_scratchpad_responder #(
    parameter int unsigned          DataWidth = 64,
    parameter int unsigned          Depth     = 256,
    parameter int unsigned          AddrWidth = 49,
    parameter logic [AddrWidth-1:0] BaseAddr  = '0,
    parameter int unsigned          Latency   = 2,
    parameter int unsigned          SidWidth  = 3,
    parameter int unsigned          TidWidth  = 6
) (
    input logic clk_i,
    input logic rst_ni,
    hpdcache_req_scratchpad_responder_if.slave bus
);
    localparam int Nb  = int'(DataWidth / 8);
    localparam int Off = $clog2(Nb);
    localparam int Iw  = $clog2(Depth);
    localparam int Hi  = Off + Iw;

    typedef enum logic {INIT, RUN} state_e;

    typedef struct packed {
        logic [DataWidth-1:0] rdata;
        logic [SidWidth-1:0]  sid;
        logic [TidWidth-1:0]  tid;
        logic                 error;
    } ent_t;

    state_e               state_q, state_d;
    logic [Iw-1:0]        cnt_q, cnt_d;
    logic [DataWidth-1:0] mem [Depth];

    logic          accept;
    logic          in_range;
    logic          err;
    logic [Iw-1:0] idx;
    ent_t          ent_in;

    logic pv [Latency];
    ent_t pd [Latency];

    assign accept = bus.req_valid_i && bus.req_ready_o;
    assign idx    = bus.req_addr_i[Off +: Iw];

    if (Hi < int'(AddrWidth)) begin : g_rng
        assign in_range = bus.req_addr_i[AddrWidth-1:Hi] == BaseAddr[AddrWidth-1:Hi];
    end else begin : g_full
        assign in_range = 1'b1;
    end

    assign err = !in_range || bus.req_op_i[1];

    // Read sees the word as it stood before this edge.
    assign ent_in.rdata = err ? '0 : mem[idx];
    assign ent_in.sid   = bus.req_sid_i;
    assign ent_in.tid   = bus.req_tid_i;
    assign ent_in.error = err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == Iw'(Depth - 1)) state_d = RUN;
            end
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    assign bus.req_ready_o = (state_q == RUN);

    always_ff @(posedge clk_i) begin
        if (state_q == INIT) begin
            mem[cnt_q] <= '0;
        end else if (accept && bus.req_op_i == 2'd1 && !err) begin
            for (int i = 0; i < Nb; i++) begin
                if (bus.req_be_i[i]) mem[idx][8*i +: 8] <= bus.req_wdata_i[8*i +: 8];
            end
        end
    end

    // Payload moves only with a valid entry, so the last stage holds
    // the most recent response across bubbles and idle cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < int'(Latency); k++) begin
                pv[k] <= 1'b0;
                pd[k] <= '0;
            end
        end else begin
            pv[0] <= accept && bus.req_need_rsp_i;
            if (accept && bus.req_need_rsp_i) pd[0] <= ent_in;
            for (int k = 1; k < int'(Latency); k++) begin
                pv[k] <= pv[k-1];
                if (pv[k-1]) pd[k] <= pd[k-1];
            end
        end
    end

    assign bus.rsp_valid_o = pv[Latency-1];
    assign bus.rsp_rdata_o = pd[Latency-1].rdata;
    assign bus.rsp_sid_o   = pd[Latency-1].sid;
    assign bus.rsp_tid_o   = pd[Latency-1].tid;
    assign bus.rsp_error_o = pd[Latency-1].error;

    a_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.req_valid_i && !bus.req_ready_o |=> bus.req_valid_i &&
        $stable({bus.req_addr_i, bus.req_op_i, bus.req_wdata_i, bus.req_be_i,
                 bus.req_sid_i, bus.req_tid_i, bus.req_need_rsp_i}));

    a_lat: assert property (@(posedge clk_i) Latency >= 1 && Latency <= 4);

    a_base: assert property (@(posedge clk_i)
        (BaseAddr & AddrWidth'(Depth * DataWidth / 8 - 1)) == '0);
endmodule
